// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider on the clk_10k domain.
// Optional macro CLK_DIV_PROG_SYNC_EN adds a sync_in port for phase alignment.
module clk_div_prog #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic             clk_10k,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
`ifdef CLK_DIV_PROG_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             upd_pending,
    output logic             running
);

    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;

    localparam logic [CNT_W-1:0] DivInit = CNT_W'((DEF_DIV < 2) ? 2 : DEF_DIV);

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(2)) ? CNT_W'(2) : v;
    endfunction

    // One bit wider so D=2^CNT_W-1 does not overflow when rounding up.
    function automatic logic [CNT_W:0] high_time(input logic [CNT_W-1:0] d);
        return ({1'b0, d} + (CNT_W+1)'(1)) >> 1;
    endfunction

    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             upd_pending_q, upd_pending_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] div_in;
    logic [CNT_W-1:0] div_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             boundary;
    logic             sync_go;

`ifdef CLK_DIV_PROG_SYNC_EN
    // A concurrent disable wins over sync so the current period still completes.
    assign sync_go = sync_in & en;
`else
    assign sync_go = 1'b0;
`endif

    always_comb begin
        div_in   = clamp_div(div_val);
        cnt_inc  = cnt_q + CNT_W'(1);
        boundary = (cnt_q == div_cur_q - CNT_W'(1));
        // A load in the restart cycle bypasses the pending register.
        div_next = div_load ? div_in : (upd_pending_q ? div_pend_q : div_cur_q);

        state_d       = state_q;
        cnt_d         = cnt_q;
        div_cur_d     = div_cur_q;
        div_pend_d    = div_pend_q;
        upd_pending_d = upd_pending_q;
        clk_out_d     = clk_out_q;
        tick_d        = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d         = '0;
                clk_out_d     = 1'b0;
                upd_pending_d = 1'b0;
                if (div_load) begin
                    div_cur_d = div_in;
                end
                if (en) begin
                    state_d   = StRun;
                    clk_out_d = 1'b1;
                    tick_d    = 1'b1;
                end
            end
            default: begin
                if (boundary && !en) begin
                    // Pending divisor is committed on the way out so IDLE never holds one.
                    state_d       = StIdle;
                    cnt_d         = '0;
                    clk_out_d     = 1'b0;
                    div_cur_d     = div_next;
                    upd_pending_d = 1'b0;
                end else if (boundary || sync_go) begin
                    cnt_d         = '0;
                    clk_out_d     = 1'b1;
                    tick_d        = 1'b1;
                    div_cur_d     = div_next;
                    upd_pending_d = 1'b0;
                end else begin
                    cnt_d     = cnt_inc;
                    clk_out_d = ({1'b0, cnt_inc} < high_time(div_cur_q));
                    if (div_load) begin
                        div_pend_d    = div_in;
                        upd_pending_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_10k) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            div_cur_q     <= DivInit;
            div_pend_q    <= DivInit;
            upd_pending_q <= 1'b0;
            clk_out_q     <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            div_cur_q     <= div_cur_d;
            div_pend_q    <= div_pend_d;
            upd_pending_q <= upd_pending_d;
            clk_out_q     <= clk_out_d;
            tick_q        <= tick_d;
        end
    end

    assign clk_out     = clk_out_q;
    assign tick        = tick_q;
    assign upd_pending = upd_pending_q;
    assign running     = (state_q == StRun);

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus randomized traffic
// compared against a period/position reference model.
module tb_clk_div_prog;

    logic        clk_10k = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] div_val;
    logic        div_load;
    logic        sync_in;
    logic        clk_out;
    logic        tick;
    logic        upd_pending;
    logic        running;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: running flag, position within the current period, period length.
    bit m_run;
    int m_pos;
    int m_d;
    bit m_pend;
    int m_pend_v;

    always #5 clk_10k = ~clk_10k;

    clk_div_prog #(
        .CNT_W   (16),
        .DEF_DIV (2)
    ) u_dut (
        .clk_10k     (clk_10k),
        .rst_n       (rst_n),
        .en          (en),
        .div_val     (div_val),
        .div_load    (div_load),
`ifdef CLK_DIV_PROG_SYNC_EN
        .sync_in     (sync_in),
`endif
        .clk_out     (clk_out),
        .tick        (tick),
        .upd_pending (upd_pending),
        .running     (running)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int clamp_i(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_update();
        bit sync_go;
`ifdef CLK_DIV_PROG_SYNC_EN
        sync_go = sync_in && en;
`else
        sync_go = 1'b0;
`endif
        if (!rst_n) begin
            m_run = 0; m_pos = 0; m_d = 2; m_pend = 0;
        end else if (!m_run) begin
            if (div_load) m_d = clamp_i(int'(div_val));
            if (en) begin
                m_run = 1; m_pos = 0;
            end
        end else begin
            bit last = (m_pos == m_d - 1);
            if (last || (sync_go && en)) begin
                if (div_load) m_d = clamp_i(int'(div_val));
                else if (m_pend) m_d = m_pend_v;
                m_pend = 0;
                m_pos  = 0;
                if (last && !en) m_run = 0;
            end else begin
                m_pos++;
                if (div_load) begin
                    m_pend_v = clamp_i(int'(div_val));
                    m_pend   = 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk_10k);
        model_update();
        #1;
        check_eq("clk_out", int'(clk_out), int'(m_run && (m_pos < (m_d + 1) / 2)));
        check_eq("tick", int'(tick), int'(m_run && m_pos == 0));
        check_eq("running", int'(running), int'(m_run));
        check_eq("upd_pending", int'(upd_pending), int'(m_pend));
    endtask

    task automatic load(input int v);
        div_val  = 16'(v);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 70000 && running; k++) step();
        check_eq("idle_reached", int'(running), 0);
    endtask

    task automatic wait_pos(input int d, input int pos);
        int k = 0;
        while (!(m_run && m_d == d && m_pos == pos) && k < 200) begin
            step();
            k++;
        end
        check_eq("pos_reached", int'(k < 200), 1);
    endtask

    initial begin
        int highs;
        int ticks;
        rst_n = 1'b0; en = 1'b0; div_val = '0; div_load = 1'b0; sync_in = 1'b0;
        m_run = 0; m_pos = 0; m_d = 2; m_pend = 0; m_pend_v = 2;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Legacy /2 after reset.
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("legacy_clk", int'(clk_out), int'(i % 2 == 0));
        end

        // D=5 loaded in IDLE.
        en = 1'b0;
        wait_idle();
        load(5);
        check_eq("idle_no_pending", int'(upd_pending), 0);
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            check_eq("d5_clk", int'(clk_out), int'((i % 5) < 3));
        end

        // Running D=4, load D=6 at cnt=1.
        load(4);
        wait_pos(4, 1);
        load(6);
        check_eq("pend_set", int'(upd_pending), 1);
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            highs += int'(clk_out);
        end
        check_eq("d4_to_d6_highs", highs, 4);
        check_eq("pend_cleared", int'(upd_pending), 0);

        // Running D=6, drop en at cnt=1: period completes, no extra tick.
        wait_pos(6, 1);
        en = 1'b0;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            ticks += int'(tick);
        end
        check_eq("disable_ticks", ticks, 0);
        check_eq("disable_idle", int'(running), 0);

        // Clamp of 0 and 1.
        load(0);
        en = 1'b1;
        step();
        step();
        check_eq("clamp0_low", int'(clk_out), 0);
        load(1);
        wait_pos(2, 0);
        step();
        check_eq("clamp1_low", int'(clk_out), 0);

        // Reset mid-run discards a pending divisor.
        load(9);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("rst_pending", int'(upd_pending), 0);

        // Widest divisor: 32768 high, 32767 low.
        en = 1'b0;
        step();
        load(65535);
        en = 1'b1;
        highs = 0;
        for (int i = 0; i < 65535; i++) begin
            step();
            highs += int'(clk_out);
        end
        check_eq("d65535_highs", highs, 32768);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

`ifdef CLK_DIV_PROG_SYNC_EN
        load(8);
        en = 1'b1;
        wait_pos(8, 5);
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        check_eq("sync_tick", int'(tick), 1);
        highs = 1;
        for (int i = 0; i < 7; i++) begin
            step();
            highs += int'(clk_out);
        end
        check_eq("sync_highs", highs, 4);
`endif

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            en       = ($urandom_range(0, 15) != 0);
            div_load = ($urandom_range(0, 7) == 0);
            div_val  = 16'($urandom_range(0, 9));
`ifdef CLK_DIV_PROG_SYNC_EN
            sync_in  = ($urandom_range(0, 11) == 0);
`endif
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
